// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM responder for the MAR/MDR interface (optional MEM_WRITE_ECHO_EN)
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter is loaded with WAIT_CYCLES-1 so WAIT spans exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic [3:0]        next_cnt;
    logic              accept;
    logic              conflict;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign accept   = (state == S_IDLE) && (read ^ write);
    assign conflict = (state == S_IDLE) && read && write;

    // Next-state and wait-counter logic.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = S_ACCESS;
                    end else begin
                        next_state = S_WAIT;
                        next_cnt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = S_ACCESS;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            S_ACCESS: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // State, request latches, read data and registered status outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            Mdatain <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            done  <= (next_state == S_DONE);
            busy  <= (next_state != S_IDLE);
            err   <= conflict;
            if (accept) begin
                op_wr   <= write;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == S_ACCESS) begin
                if (!op_wr) begin
                    Mdatain <= mem[addr_q];
                end
`ifdef MEM_WRITE_ECHO_EN
                else begin
                    Mdatain <= wdata_q;
                end
`else
`endif
            end
        end
    end

    // Array write; state is already IDLE if reset hit before ACCESS closed.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && op_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
